// File: rtl/tmr_pkg.sv
// Shared types and replica indices for the TMR voter/monitor.
package tmr_pkg;

    typedef enum logic [1:0] {
        ST_OK      = 2'd0,
        ST_SUSPECT = 2'd1,
        ST_FAILED  = 2'd2
    } replica_state_e;

    localparam int unsigned NUM_REPLICAS = 3;
    localparam int unsigned IDX_A        = 0;
    localparam int unsigned IDX_B        = 1;
    localparam int unsigned IDX_C        = 2;

endpackage

// File: rtl/tmr_replica_monitor.sv
// Per-replica health tracker: mismatch-streak FSM plus saturating error counter.
module tmr_replica_monitor
    import tmr_pkg::*;
#(
    parameter int unsigned PERSIST   = 4,
    parameter int unsigned CNT_WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_valid,
    input  logic                 i_mismatch,
    input  logic                 i_clear,
    output logic                 o_failed,
    output logic [CNT_WIDTH-1:0] o_err_cnt
);

    localparam int unsigned SW = $clog2(PERSIST + 1);
    localparam logic [SW-1:0] STREAK_MAX = SW'(PERSIST);

    replica_state_e       r_state;
    replica_state_e       w_state_nxt;
    logic [SW-1:0]        r_streak;
    logic [SW-1:0]        w_streak_nxt;
    logic [CNT_WIDTH-1:0] r_cnt;
    logic [CNT_WIDTH-1:0] w_cnt_nxt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= ST_OK;
            r_streak <= '0;
            r_cnt    <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_streak <= w_streak_nxt;
            r_cnt    <= w_cnt_nxt;
        end
    end

    // Clear dominates; otherwise only valid samples move the FSM and counter.
    always_comb begin
        w_state_nxt  = r_state;
        w_streak_nxt = r_streak;
        w_cnt_nxt    = r_cnt;
        if (i_clear) begin
            w_state_nxt  = ST_OK;
            w_streak_nxt = '0;
            w_cnt_nxt    = '0;
        end else if (i_valid) begin
            if (i_mismatch && (r_cnt != '1)) begin
                w_cnt_nxt = r_cnt + CNT_WIDTH'(1);
            end
            case (r_state)
                ST_OK: begin
                    if (i_mismatch) begin
                        w_streak_nxt = SW'(1);
                        w_state_nxt  = (STREAK_MAX == SW'(1)) ? ST_FAILED : ST_SUSPECT;
                    end
                end
                ST_SUSPECT: begin
                    if (i_mismatch) begin
                        w_streak_nxt = r_streak + SW'(1);
                        if (w_streak_nxt == STREAK_MAX) begin
                            w_state_nxt = ST_FAILED;
                        end
                    end else begin
                        w_state_nxt  = ST_OK;
                        w_streak_nxt = '0;
                    end
                end
                ST_FAILED: begin
                    w_state_nxt = ST_FAILED;
                end
                default: begin
                    w_state_nxt  = ST_OK;
                    w_streak_nxt = '0;
                end
            endcase
        end
    end

    assign o_failed  = (r_state == ST_FAILED);
    assign o_err_cnt = r_cnt;

endmodule

// File: rtl/tmr_voter_monitor.sv
// Registered bitwise-majority TMR voter with per-replica failure tracking and
// degraded-mode steering to the last healthy replica.
module tmr_voter_monitor
    import tmr_pkg::*;
#(
    parameter int unsigned WIDTH     = 8,
    parameter int unsigned PERSIST   = 4,
    parameter int unsigned CNT_WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 valid_in,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    input  logic [WIDTH-1:0]     c,
    input  logic                 clear_fail,
    output logic [WIDTH-1:0]     out,
    output logic                 valid_out,
    output logic [2:0]           mismatch,
    output logic [2:0]           failed,
    output logic                 all_failed,
    output logic [CNT_WIDTH-1:0] err_cnt_a,
    output logic [CNT_WIDTH-1:0] err_cnt_b,
    output logic [CNT_WIDTH-1:0] err_cnt_c
);

    logic [WIDTH-1:0]     w_word [NUM_REPLICAS];
    logic [CNT_WIDTH-1:0] w_cnt  [NUM_REPLICAS];
    logic [WIDTH-1:0]     w_maj;
    logic [WIDTH-1:0]     w_vote;
    logic [2:0]           w_mis;
    logic [2:0]           w_failed;
    logic [WIDTH-1:0]     r_out;
    logic                 r_valid;
    logic [2:0]           r_mis;

    assign w_word[IDX_A] = a;
    assign w_word[IDX_B] = b;
    assign w_word[IDX_C] = c;
    assign w_maj = (a & b) | (b & c) | (a & c);

    for (genvar gi = 0; gi < NUM_REPLICAS; gi++) begin : g_mon
        assign w_mis[gi] = (w_word[gi] != w_maj);

        tmr_replica_monitor #(
            .PERSIST   (PERSIST),
            .CNT_WIDTH (CNT_WIDTH)
        ) u_mon (
            .clk        (clk),
            .rst        (rst),
            .i_valid    (valid_in),
            .i_mismatch (w_mis[gi]),
            .i_clear    (clear_fail),
            .o_failed   (w_failed[gi]),
            .o_err_cnt  (w_cnt[gi])
        );
    end

    // With exactly two replicas failed, pass the survivor through untouched.
    always_comb begin
        w_vote = w_maj;
        case (w_failed)
            3'b011:  w_vote = w_word[IDX_C];
            3'b101:  w_vote = w_word[IDX_B];
            3'b110:  w_vote = w_word[IDX_A];
            default: w_vote = w_maj;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out   <= '0;
            r_valid <= 1'b0;
            r_mis   <= '0;
        end else if (valid_in) begin
            r_out   <= w_vote;
            r_valid <= 1'b1;
            r_mis   <= w_mis;
        end else begin
            r_valid <= 1'b0;
            r_mis   <= '0;
        end
    end

    assign out        = r_out;
    assign valid_out  = r_valid;
    assign mismatch   = r_mis;
    assign failed     = w_failed;
    assign all_failed = &w_failed;
    assign err_cnt_a  = w_cnt[IDX_A];
    assign err_cnt_b  = w_cnt[IDX_B];
    assign err_cnt_c  = w_cnt[IDX_C];

endmodule

// File: doc/tmr_voter_monitor.md
# tmr_voter_monitor

Registered, parametrised triple-modular-redundancy voter with per-replica fault monitoring. Votes three replica words bitwise-majority, registers the result with a valid flag, and tracks each replica's disagreement history. A replica is declared failed after PERSIST consecutive mismatching valid samples. Sits at the output of triplicated datapaths, replacing the plain combinational voter wherever fault reporting and degraded-mode steering are required.

## Interface
- WIDTH, 8, width of each replica word and of the voted output
- PERSIST, 4, consecutive mismatching valid samples needed to declare a replica failed (≥1)
- CNT_WIDTH, 8, width of each per-replica saturating error counter
- clk  input  1  sole clock, rising edge
- rst  input  1  asynchronous, active-high reset
- valid_in  input  1  a/b/c carry a sample this cycle
- a, b, c  input  WIDTH each  replica words
- clear_fail  input  1  synchronous clear of all fail state, streaks and counters
- out  output  WIDTH  registered voted word
- valid_out  output  1  out is valid
- mismatch  output  3  registered; bit i set if replica i ≠ majority on the sample presented at out ({c,b,a} = bits 2..0)
- failed  output  3  sticky per-replica failed flags
- all_failed  output  1  all three failed bits set
- err_cnt_a, err_cnt_b, err_cnt_c  output  CNT_WIDTH each  saturating count of mismatching valid samples

## Operation
- maj = (a&b)|(b&c)|(a&c), bitwise.
- Voting by number of failed replicas: 0 or 1 → out_next = maj; exactly 2 → out_next = remaining healthy replica unchanged; 3 → out_next = maj and all_failed = 1.
- Replica i mismatches when its word ≠ maj (compared against maj, not against the steered output).
- Per-replica FSM, advanced only on valid_in cycles:
  - OK: mismatch → SUSPECT with streak = 1 (straight to FAILED if PERSIST = 1); match → stay.
  - SUSPECT: mismatch → streak+1, FAILED when streak reaches PERSIST; match → OK, streak = 0.
  - FAILED: absorbing; exit only via clear_fail or rst.
- failed[i] = (state == FAILED).
- err_cnt_i increments on each mismatching valid sample in every state, saturating at 2^CNT_WIDTH−1.
- clear_fail wins over a same-cycle mismatch: state → OK, streak = 0, counter = 0; that sample still votes and reports mismatch, but is not counted.
- valid_in = 0: out holds, valid_out = 0, mismatch = 0, FSMs and counters unchanged.

## Timing
- Latency 1 cycle: sample at edge N → out/valid_out/mismatch valid after edge N.
- failed and counters reflect the sample at edge N after the same edge; steering changes from the next sample.
- Reset (async assert, held until deassert): out = 0, valid_out = 0, mismatch = 0, failed = 0, all_failed = 0, counters = 0, all FSMs OK, streaks 0. Reset mid-streak discards history.
- Three-way disagreement (e.g. 11/22/44 → maj 00): all three mismatch in the same cycle, all streaks advance together.
- Non-consecutive mismatches separated by any matching valid sample never reach FAILED; invalid cycles between samples do not break a streak.

## Structure
- Package tmr_pkg: replica-state typedef (OK, SUSPECT, FAILED), replica index constants IDX_A=0, IDX_B=1, IDX_C=2.
- Sub-module tmr_replica_monitor (FSM, streak counter, saturating err counter), instantiated three times; top holds majority logic, steering mux and output registers.

## Test plan
- Reset, then valid samples 00/00/FF, FF/FF/00, 22/22/10 → out 00, FF, 22 one cycle later; mismatch 100, 100, 100; no failed.
- PERSIST=4, c = 0F vs a = b = F0 for 4 consecutive valid samples → failed = 100 after 4th; err_cnt_c = 4; out stays F0.
- b mismatches 3 samples, one match, 3 more → failed stays 000, err_cnt_b = 6.
- Fail b and c (a = 5A, b = 00, c = FF for 4 samples), then a = 3C, b = 3C, c = 3C with a healthy → out = 3C; then a = 11, b = c = 22 → out 11 (steered to a).
- 11/22/44 for 4 samples → out 00, mismatch 111, failed 111, all_failed 1; clear_fail with a mismatch → failed 000, counters 0.
- CNT_WIDTH=2, 5 mismatches on a → err_cnt_a saturates at 3; async rst mid-run clears all outputs immediately.
